apb4_archinfo_seq: RTL and testbench

//  APB4 master-side sequencer for the archinfo register block (SYS @+0x0, IDL @+0x4, IDH @+0x8).

---
 rtl/apb4_archinfo_seq_if.sv | 25 ++
 rtl/apb4_archinfo_seq.sv | 180 ++++++++++++++++++
 tb/tb_apb4_archinfo_seq.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb4_archinfo_seq_if.sv
// APB4 bus bundle between the archinfo sequencer (master) and the register block (slave).
interface apb4_archinfo_seq_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [31:0]           pwdata;
    logic [3:0]            pstrb;
    logic [2:0]            pprot;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb4_archinfo_seq.sv
// APB4 master that scans the archinfo registers (SYS, IDL, IDH) into shadow copies and
// shares the bus with one local write port; a pending write always wins over a scan.
module apb4_archinfo_seq #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    TIMEOUT_CYC = 255,
    parameter bit                    AUTO_SCAN   = 1'b1
) (
    input  logic                      pclk,
    input  logic                      preset,
    apb4_archinfo_seq_if.master       apb,
    input  logic                      scan_i,
    input  logic                      wr_req_i,
    input  logic [1:0]                wr_sel_i,
    input  logic [31:0]               wr_data_i,
    output logic                      wr_ack_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      valid_o,
    output logic                      err_o,
    output logic [31:0]               sys_o,
    output logic [31:0]               idl_o,
    output logic [31:0]               idh_o
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    // ST_GAP is the one idle bus cycle after a timed-out read, before the next register's SETUP.
    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_ACCESS, ST_GAP, ST_FIN
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  psel_q, penable_q, pwrite_q;
    logic [31:0]           pwdata_q;
    logic [3:0]            pstrb_q;
    logic [1:0]            idx_q;
    logic                  is_wr_q, pend_q, scan_err_q;
    logic [CW-1:0]         wait_cnt_q;
    logic                  done_q, wr_ack_q, valid_q, err_q;
    logic [31:0]           sys_q, idl_q, idh_q;

    logic                  timeout_d, xfer_end_d, xfer_err_d;
    logic [31:0]           ld_data_d;
    logic [1:0]            idx_next_d;

    function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [1:0] i);
        return BASE_ADDR + ADDR_WIDTH'({i, 2'b00});
    endfunction

    always_comb begin
        timeout_d  = (TIMEOUT_CYC != 0) && !apb.pready && (wait_cnt_q == CW'(TIMEOUT_CYC - 1));
        xfer_end_d = (state_q == ST_ACCESS) && (apb.pready || timeout_d);
        xfer_err_d = timeout_d || (apb.pready && apb.pslverr);
        ld_data_d  = is_wr_q ? pwdata_q : apb.prdata;
        idx_next_d = idx_q + 2'd1;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= ST_IDLE;
            paddr_q    <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            idx_q      <= '0;
            is_wr_q    <= 1'b0;
            pend_q     <= AUTO_SCAN;
            scan_err_q <= 1'b0;
            wait_cnt_q <= '0;
            done_q     <= 1'b0;
            wr_ack_q   <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            sys_q      <= '0;
            idl_q      <= '0;
            idh_q      <= '0;
        end else begin
            done_q   <= 1'b0;
            wr_ack_q <= 1'b0;
            if (scan_i) pend_q <= 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (wr_req_i) begin
                        if (wr_sel_i == 2'd3) begin
                            err_q    <= 1'b1;
                            wr_ack_q <= 1'b1;
                            state_q  <= ST_FIN;
                        end else begin
                            is_wr_q  <= 1'b1;
                            idx_q    <= wr_sel_i;
                            paddr_q  <= reg_addr(wr_sel_i);
                            pwrite_q <= 1'b1;
                            pwdata_q <= wr_data_i;
                            pstrb_q  <= 4'hF;
                            psel_q   <= 1'b1;
                            state_q  <= ST_SETUP;
                        end
                    end else if (pend_q || scan_i) begin
                        pend_q     <= 1'b0;
                        err_q      <= 1'b0;
                        valid_q    <= 1'b0;
                        scan_err_q <= 1'b0;
                        is_wr_q    <= 1'b0;
                        idx_q      <= 2'd0;
                        paddr_q    <= reg_addr(2'd0);
                        pwrite_q   <= 1'b0;
                        pwdata_q   <= '0;
                        pstrb_q    <= 4'h0;
                        psel_q     <= 1'b1;
                        state_q    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q  <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!xfer_end_d) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end else begin
                        penable_q <= 1'b0;
                        if (xfer_err_d) begin
                            err_q <= 1'b1;
                        end else begin
                            case (idx_q)
                                2'd0:    sys_q <= ld_data_d;
                                2'd1:    idl_q <= ld_data_d;
                                2'd2:    idh_q <= ld_data_d;
                                default: ;
                            endcase
                        end
                        if (is_wr_q) begin
                            psel_q   <= 1'b0;
                            wr_ack_q <= 1'b1;
                            state_q  <= ST_FIN;
                        end else if (idx_q == 2'd2) begin
                            psel_q  <= 1'b0;
                            done_q  <= 1'b1;
                            valid_q <= !(scan_err_q || xfer_err_d);
                            state_q <= ST_FIN;
                        end else begin
                            scan_err_q <= scan_err_q || xfer_err_d;
                            idx_q      <= idx_next_d;
                            paddr_q    <= reg_addr(idx_next_d);
                            psel_q     <= !timeout_d;
                            state_q    <= timeout_d ? ST_GAP : ST_SETUP;
                        end
                    end
                end
                ST_GAP: begin
                    psel_q  <= 1'b1;
                    state_q <= ST_SETUP;
                end
                ST_FIN: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign apb.paddr   = paddr_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pstrb   = pstrb_q;
    assign apb.pprot   = 3'b000;

    assign wr_ack_o = wr_ack_q;
    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = done_q;
    assign valid_o  = valid_q;
    assign err_o    = err_q;
    assign sys_o    = sys_q;
    assign idl_o    = idl_q;
    assign idh_o    = idh_q;
endmodule

// File: tb/tb_apb4_archinfo_seq.sv
// Directed bench for apb4_archinfo_seq: behavioural APB slave, transfer scoreboard,
// a table of scan scenarios and hand-written write/reset sequences.
module tb_apb4_archinfo_seq;
    localparam int AW  = 32;
    localparam int TMO = 4;

    logic pclk   = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    apb4_archinfo_seq_if #(.ADDR_WIDTH(AW)) apb ();

    logic        scan_i    = 1'b0;
    logic        wr_req_i  = 1'b0;
    logic [1:0]  wr_sel_i  = 2'd0;
    logic [31:0] wr_data_i = 32'h0;
    logic        wr_ack_o, busy_o, done_o, valid_o, err_o;
    logic [31:0] sys_o, idl_o, idh_o;

    apb4_archinfo_seq #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  ('0),
        .TIMEOUT_CYC(TMO),
        .AUTO_SCAN  (1'b1)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .apb      (apb),
        .scan_i   (scan_i),
        .wr_req_i (wr_req_i),
        .wr_sel_i (wr_sel_i),
        .wr_data_i(wr_data_i),
        .wr_ack_o (wr_ack_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .valid_o  (valid_o),
        .err_o    (err_o),
        .sys_o    (sys_o),
        .idl_o    (idl_o),
        .idh_o    (idh_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural slave: per-register data, wait states and error flags.
    logic [31:0] cfg_data [4];
    int          cfg_wait [4];
    logic        cfg_serr [4];
    logic        cfg_load = 1'b0;
    logic [31:0] sregs [4];
    int          wcnt = 0;
    logic [1:0]  sidx;
    logic        acc;

    assign sidx        = apb.paddr[3:2];
    assign acc         = apb.psel && apb.penable;
    assign apb.pready  = acc && (wcnt >= cfg_wait[sidx]);
    assign apb.pslverr = apb.pready && cfg_serr[sidx];
    assign apb.prdata  = (acc && !apb.pwrite) ? sregs[sidx] : 32'h0;

    always @(posedge pclk) begin
        wcnt <= (acc && !apb.pready) ? wcnt + 1 : 0;
        if (cfg_load) begin
            for (int i = 0; i < 4; i++) sregs[i] <= cfg_data[i];
        end else if (apb.pready && apb.pwrite && !apb.pslverr) begin
            sregs[sidx] <= apb.pwdata;
        end
    end

    // Scoreboard of completed transfers: {pwrite, paddr[7:0], data}.
    logic [40:0] exp_q [$];
    logic [63:0] cap;

    always @(negedge pclk) begin
        if (!preset) begin
            if (apb.psel && !apb.penable) cap <= {apb.pwrite, apb.paddr[30:0], apb.pwdata};
            if (acc) check("apb_hold", {apb.pwrite, apb.paddr[30:0], apb.pwdata}, cap);
            if (apb.psel) begin
                check("psel_outside_xfer", !busy_o || done_o || wr_ack_o, 1'b0);
                check("pprot", apb.pprot, 3'b000);
            end
            if (apb.pready) begin
                check("pstrb", apb.pstrb, apb.pwrite ? 4'hF : 4'h0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL apb_xfer: unexpected transfer paddr 0x%0h pwrite %0b", apb.paddr, apb.pwrite);
                end else begin
                    check("apb_xfer", {apb.pwrite, apb.paddr[7:0], apb.pwrite ? apb.pwdata : apb.prdata},
                          exp_q.pop_front());
                end
            end
        end
    end

    task automatic set_slave(input logic [31:0] d0, d1, d2, input int w0, w1, w2, input logic [2:0] serr);
        cfg_data[0] = d0; cfg_data[1] = d1; cfg_data[2] = d2; cfg_data[3] = 32'h0;
        cfg_wait[0] = w0; cfg_wait[1] = w1; cfg_wait[2] = w2; cfg_wait[3] = 0;
        cfg_serr[0] = serr[0]; cfg_serr[1] = serr[1]; cfg_serr[2] = serr[2]; cfg_serr[3] = 1'b0;
        cfg_load = 1'b1;
        @(negedge pclk);
        cfg_load = 1'b0;
    endtask

    task automatic push_rd(input int i, input logic [31:0] d);
        exp_q.push_back({1'b0, 8'(4 * i), d});
    endtask

    // Called at a negedge; the cycle now in progress is cycle 0.
    task automatic scan_wait(input logic do_scan, output int cyc);
        scan_i = do_scan;
        @(negedge pclk);
        scan_i = 1'b0;
        cyc = 1;
        while (!done_o && cyc < 64) begin
            @(negedge pclk);
            cyc++;
        end
        check("done_seen", done_o, 1'b1);
    endtask

    task automatic do_write(input logic [1:0] sel, input logic [31:0] d, output int cyc, output logic saw_psel);
        wr_req_i  = 1'b1;
        wr_sel_i  = sel;
        wr_data_i = d;
        saw_psel  = 1'b0;
        @(negedge pclk);
        cyc = 1;
        while (!wr_ack_o && cyc < 64) begin
            saw_psel = saw_psel | apb.psel;
            @(negedge pclk);
            cyc++;
        end
        check("wr_ack_seen", wr_ack_o, 1'b1);
        wr_req_i = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_apb_ctl"}, {apb.psel, apb.penable, apb.pwrite, apb.pstrb}, 7'd0);
        check({tag, "_paddr"}, apb.paddr, 0);
        check({tag, "_pwdata"}, apb.pwdata, 0);
        check({tag, "_flags"}, {busy_o, done_o, valid_o, err_o, wr_ack_o}, 5'd0);
        check({tag, "_sys"}, sys_o, 0);
        check({tag, "_idl"}, idl_o, 0);
        check({tag, "_idh"}, idh_o, 0);
    endtask

    typedef struct {
        logic [31:0] d0, d1, d2;
        int          w0, w1, w2;
        logic [2:0]  serr;
        int          done_cyc;
        logic        err, valid;
        logic [31:0] sys, idl, idh;
    } vec_t;

    vec_t vt [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, ack_cyc;
        logic        saw;

        // Wait 99 = stuck slave, aborted after TMO wait cycles.
        vt[0] = '{32'hA1, 32'hA2, 32'hA3, 0, 0, 0,  3'b000,  7, 1'b0, 1'b1, 32'hA1, 32'hA2, 32'hA3};
        vt[1] = '{32'hB1, 32'hB2, 32'hB3, 0, 3, 0,  3'b000, 10, 1'b0, 1'b1, 32'hB1, 32'hB2, 32'hB3};
        vt[2] = '{32'hC1, 32'hC2, 32'hC3, 99, 0, 0, 3'b000, 11, 1'b1, 1'b0, 32'hB1, 32'hC2, 32'hC3};
        vt[3] = '{32'hD1, 32'hD2, 32'hD3, 0, 0, 0,  3'b100,  7, 1'b1, 1'b0, 32'hD1, 32'hD2, 32'hC3};
        vt[4] = '{32'hE1, 32'hE2, 32'hE3, 0, 0, 0,  3'b000,  7, 1'b0, 1'b1, 32'hE1, 32'hE2, 32'hE3};
        vt[5] = '{32'hF1, 32'hF2, 32'hF3, 1, 2, 1,  3'b000, 11, 1'b0, 1'b1, 32'hF1, 32'hF2, 32'hF3};
        vt[6] = '{32'h61, 32'h62, 32'h63, 2, 0, 0,  3'b001,  9, 1'b1, 1'b0, 32'hF1, 32'h62, 32'h63};
        vt[7] = '{32'h71, 32'h72, 32'h73, 0, 0, 99, 3'b000, 10, 1'b1, 1'b0, 32'h71, 32'h72, 32'h63};

        // Reset and automatic scan after release.
        set_slave(32'h11, 32'h22, 32'h33, 0, 0, 0, 3'b000);
        repeat (2) @(negedge pclk);
        check_zero("reset");
        push_rd(0, 32'h11); push_rd(1, 32'h22); push_rd(2, 32'h33);
        preset = 1'b0;
        scan_wait(1'b0, cyc);
        check("auto_done_cyc", cyc, 7);
        check("auto_valid_err", {valid_o, err_o}, 2'b10);
        check("auto_sys", sys_o, 32'h11);
        check("auto_idl", idl_o, 32'h22);
        check("auto_idh", idh_o, 32'h33);
        @(negedge pclk);
        check("auto_idle", {busy_o, done_o}, 2'b00);

        for (int k = 0; k < 8; k++) begin
            set_slave(vt[k].d0, vt[k].d1, vt[k].d2, vt[k].w0, vt[k].w1, vt[k].w2, vt[k].serr);
            if (vt[k].w0 < TMO) push_rd(0, vt[k].d0);
            if (vt[k].w1 < TMO) push_rd(1, vt[k].d1);
            if (vt[k].w2 < TMO) push_rd(2, vt[k].d2);
            scan_wait(1'b1, cyc);
            check($sformatf("v%0d_done_cyc", k), cyc, vt[k].done_cyc);
            check($sformatf("v%0d_err", k), err_o, vt[k].err);
            check($sformatf("v%0d_valid", k), valid_o, vt[k].valid);
            check($sformatf("v%0d_sys", k), sys_o, vt[k].sys);
            check($sformatf("v%0d_idl", k), idl_o, vt[k].idl);
            check($sformatf("v%0d_idh", k), idh_o, vt[k].idh);
            @(negedge pclk);
            check($sformatf("v%0d_idle", k), {busy_o, done_o}, 2'b00);
        end

        // Write and scan requested together: write goes first.
        set_slave(32'h01, 32'h02, 32'h03, 0, 0, 0, 3'b000);
        exp_q.push_back({1'b1, 8'h04, 32'hDEADBEEF});
        push_rd(0, 32'h01); push_rd(1, 32'hDEADBEEF); push_rd(2, 32'h03);
        wr_req_i = 1'b1; wr_sel_i = 2'd1; wr_data_i = 32'hDEADBEEF; scan_i = 1'b1;
        @(negedge pclk);
        scan_i = 1'b0;
        cyc = 1;
        ack_cyc = 0;
        check("ws_c1_ctl", {apb.psel, apb.penable, apb.pwrite, apb.pstrb}, 7'b1011111);
        check("ws_c1_paddr", apb.paddr, 32'h4);
        while (!done_o && cyc < 64) begin
            if (wr_ack_o) begin
                ack_cyc  = cyc;
                wr_req_i = 1'b0;
            end
            @(negedge pclk);
            cyc++;
        end
        check("ws_ack_cyc", ack_cyc, 3);
        check("ws_done_cyc", cyc, 11);
        check("ws_idl", idl_o, 32'hDEADBEEF);
        check("ws_sys", sys_o, 32'h01);
        check("ws_idh", idh_o, 32'h03);
        check("ws_valid_err", {valid_o, err_o}, 2'b10);
        @(negedge pclk);

        // Write answered with pslverr: ack still pulses, shadow kept, error set.
        set_slave(32'h55, 32'h66, 32'h77, 0, 0, 0, 3'b001);
        exp_q.push_back({1'b1, 8'h00, 32'h12345678});
        do_write(2'd0, 32'h12345678, cyc, saw);
        check("werr_ack_cyc", cyc, 3);
        check("werr_err", err_o, 1'b1);
        check("werr_sys", sys_o, 32'h01);
        @(negedge pclk);

        // Clean write: shadow updated, valid and sticky error untouched.
        set_slave(32'h55, 32'h66, 32'h77, 0, 0, 0, 3'b000);
        exp_q.push_back({1'b1, 8'h08, 32'hCAFEF00D});
        do_write(2'd2, 32'hCAFEF00D, cyc, saw);
        check("wok_ack_cyc", cyc, 3);
        check("wok_idh", idh_o, 32'hCAFEF00D);
        check("wok_valid_err", {valid_o, err_o}, 2'b11);
        @(negedge pclk);
        check("wok_ack_pulse", wr_ack_o, 1'b0);

        // Reset during the IDL access, then the automatic rescan.
        set_slave(32'h91, 32'h92, 32'h93, 0, 3, 0, 3'b000);
        push_rd(0, 32'h91);
        scan_i = 1'b1;
        @(negedge pclk);
        scan_i = 1'b0;
        cyc = 1;
        while (!(apb.penable && apb.paddr == 32'h4) && cyc < 64) begin
            @(negedge pclk);
            cyc++;
        end
        check("rmid_reach_cyc", cyc, 4);
        preset = 1'b1;
        @(negedge pclk);
        check_zero("rmid");
        set_slave(32'h81, 32'h82, 32'h83, 0, 0, 0, 3'b000);
        push_rd(0, 32'h81); push_rd(1, 32'h82); push_rd(2, 32'h83);
        preset = 1'b0;
        scan_wait(1'b0, cyc);
        check("rescan_done_cyc", cyc, 7);
        check("rescan_valid_err", {valid_o, err_o}, 2'b10);
        check("rescan_sys", sys_o, 32'h81);
        check("rescan_idl", idl_o, 32'h82);
        check("rescan_idh", idh_o, 32'h83);
        @(negedge pclk);

        // Illegal write target: ack and error next cycle, no bus activity.
        do_write(2'd3, 32'h0BADF00D, cyc, saw);
        check("wsel3_ack_cyc", cyc, 1);
        check("wsel3_err", err_o, 1'b1);
        check("wsel3_no_psel", saw | apb.psel, 1'b0);
        check("wsel3_shadows", {sys_o, idl_o}, {32'h81, 32'h82});
        @(negedge pclk);
        check("wsel3_idle", busy_o, 1'b0);

        repeat (2) @(negedge pclk);
        check("exp_q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
